// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data memory access unit:
// funct3 access encodings, FSM state encoding and access-legality helpers.
package dmem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Loads accept the unsigned variants as well; stores only B/H/W.
   function automatic logic f3_legal(input logic is_read, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (is_read) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

   // f3[1:0] carries the access size for every legal encoding.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3.
// Ports: mem_rdata (word read), offset (byte offset in word),
//        funct3 (load kind), result (32-bit extended value).
module load_extend
   import dmem_access_unit_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = mem_rdata[{offset, 3'b000} +: 8];
      // Halfword offsets are 0 or 2, so only offset[1] selects the lane.
      half_v = mem_rdata[{offset[1], 4'b0000} +: 16];
      case (funct3)
         F3_B:    result = {{24{byte_v[7]}}, byte_v};
         F3_H:    result = {{16{half_v[15]}}, half_v};
         F3_BU:   result = {24'd0, byte_v};
         F3_HU:   result = {16'd0, half_v};
         default: result = mem_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: converts EX/MEM load/store controls into a
// req/ack transaction on a word-organised data memory, stalls the pipeline
// until completion and returns extended load data to write-back.
// Ports: Clk/Rst (async active-high), ValidIn/ReadIn/WriteIn/Funct3In/
//        AddrIn/StoreDataIn from EX/MEM; StallOut, DataOut, DataValidOut,
//        ErrOut to the pipeline; MemReq/MemWe/MemAddr/MemBE/MemWData/
//        MemRData/MemAck towards the data memory.
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ValidIn,
   input  logic        ReadIn,
   input  logic        WriteIn,
   input  logic [2:0]  Funct3In,
   input  logic [31:0] AddrIn,
   input  logic [31:0] StoreDataIn,
   output logic        StallOut,
   output logic [31:0] DataOut,
   output logic        DataValidOut,
   output logic        ErrOut,
   output logic        MemReq,
   output logic        MemWe,
   output logic [29:0] MemAddr,
   output logic [3:0]  MemBE,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   input  logic        MemAck
);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             acc, is_read, bad, timeout;
   logic             launch, fail;
   logic [3:0]       be_c;
   logic [31:0]      wdata_c;
   logic [31:0]      ext_data;

   // Request decode; a simultaneous read and write is treated as a read.
   always_comb begin
      acc     = ValidIn & (ReadIn | WriteIn);
      is_read = ReadIn;
      bad     = ~f3_legal(is_read, Funct3In) | misaligned(Funct3In, AddrIn[1:0]);
      timeout = (cnt == CNT_W'(TIMEOUT - 1));
   end

   // Store lane placement; reads enable all four lanes.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = StoreDataIn;
      if (!is_read) begin
         case (Funct3In[1:0])
            2'b00: begin
               be_c    = 4'b0001 << AddrIn[1:0];
               wdata_c = {4{StoreDataIn[7:0]}};
            end
            2'b01: begin
               be_c    = 4'b0011 << AddrIn[1:0];
               wdata_c = {2{StoreDataIn[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // FSM next state and stall; StallOut is combinational so the first
   // cycle of a legal access already freezes the pipeline.
   always_comb begin
      next_state = state;
      StallOut   = 1'b0;
      launch     = 1'b0;
      fail       = 1'b0;
      case (state)
         S_IDLE: begin
            if (acc) begin
               if (bad) begin
                  next_state = S_DONE;
                  fail       = 1'b1;
               end else begin
                  next_state = S_WAIT;
                  launch     = 1'b1;
                  StallOut   = 1'b1;
               end
            end
         end
         S_WAIT: begin
            StallOut = 1'b1;
            if (MemAck) begin
               next_state = S_DONE;
            end else if (timeout) begin
               next_state = S_DONE;
               fail       = 1'b1;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      // Held instruction inputs must not stall the pipeline while in reset.
      if (Rst) StallOut = 1'b0;
   end

   load_extend u_load_extend (
      .mem_rdata (MemRData),
      .offset    (off_q),
      .funct3    (f3_q),
      .result    (ext_data)
   );

   // Registered memory interface, completion pulses, counter and load data.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         MemReq       <= 1'b0;
         MemWe        <= 1'b0;
         MemAddr      <= '0;
         MemBE        <= '0;
         MemWData     <= '0;
         DataValidOut <= 1'b0;
         ErrOut       <= 1'b0;
         DataOut      <= '0;
         cnt          <= '0;
         f3_q         <= '0;
         off_q        <= '0;
      end else begin
         MemReq       <= (next_state == S_WAIT);
         DataValidOut <= (next_state == S_DONE) & ~fail;
         ErrOut       <= fail;
         cnt          <= (state == S_WAIT) ? cnt + CNT_W'(1) : '0;
         if (launch) begin
            MemWe    <= ~is_read;
            MemAddr  <= AddrIn[31:2];
            MemBE    <= be_c;
            MemWData <= wdata_c;
            f3_q     <= Funct3In;
            off_q    <= AddrIn[1:0];
         end
         if (fail)
            DataOut <= '0;
         else if ((state == S_WAIT) && MemAck && !MemWe)
            DataOut <= ext_data;
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: a table of single accesses with
// hand-computed responses, plus reset and stray-acknowledge sequences.
module tb_dmem_access_unit;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        ValidIn, ReadIn, WriteIn;
   logic [2:0]  Funct3In;
   logic [31:0] AddrIn, StoreDataIn;
   logic        StallOut;
   logic [31:0] DataOut;
   logic        DataValidOut, ErrOut;
   logic        MemReq, MemWe;
   logic [29:0] MemAddr;
   logic [3:0]  MemBE;
   logic [31:0] MemWData, MemRData;
   logic        MemAck;

   int checks = 0;
   int errors = 0;

   dmem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .ValidIn      (ValidIn),
      .ReadIn       (ReadIn),
      .WriteIn      (WriteIn),
      .Funct3In     (Funct3In),
      .AddrIn       (AddrIn),
      .StoreDataIn  (StoreDataIn),
      .StallOut     (StallOut),
      .DataOut      (DataOut),
      .DataValidOut (DataValidOut),
      .ErrOut       (ErrOut),
      .MemReq       (MemReq),
      .MemWe        (MemWe),
      .MemAddr      (MemAddr),
      .MemBE        (MemBE),
      .MemWData     (MemWData),
      .MemRData     (MemRData),
      .MemAck       (MemAck)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          ack_at;   // WAIT cycle (1-based) carrying MemAck; 0 = never
      logic [29:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_we;
      int          e_stall;
      int          e_req;
      logic        e_err;
      logic [31:0] e_dout;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int ack_at,
                               input logic [29:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic e_we,
                               input int e_stall, input int e_req, input logic e_err,
                               input logic [31:0] e_dout);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata;
      v.rdata = rdata; v.ack_at = ack_at; v.e_addr = e_addr; v.e_be = e_be;
      v.e_wdata = e_wdata; v.e_we = e_we; v.e_stall = e_stall; v.e_req = e_req;
      v.e_err = e_err; v.e_dout = e_dout;
      return v;
   endfunction

   // Presents one access, plays the memory side and checks the full response.
   task automatic run_txn(input vec_t v, input int idx);
      int  stall_n = 0;
      int  req_n   = 0;
      bit  done    = 0;
      @(negedge Clk);
      ValidIn = 1'b1; ReadIn = v.rd; WriteIn = v.wr; Funct3In = v.f3;
      AddrIn = v.addr; StoreDataIn = v.sdata; MemRData = v.rdata; MemAck = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (StallOut) stall_n++;
         if (MemReq) begin
            req_n++;
            if (req_n == 1) begin
               chk($sformatf("v%0d mem_addr", idx), 32'(MemAddr), 32'(v.e_addr));
               chk($sformatf("v%0d mem_be", idx), 32'(MemBE), 32'(v.e_be));
               chk($sformatf("v%0d mem_we", idx), 32'(MemWe), 32'(v.e_we));
               if (v.e_we) chk($sformatf("v%0d mem_wdata", idx), MemWData, v.e_wdata);
            end
         end
         MemAck = MemReq && (req_n == v.ack_at);
         if (DataValidOut || ErrOut) begin
            done = 1;
            ValidIn = 1'b0; ReadIn = 1'b0; WriteIn = 1'b0; MemAck = 1'b0;
            chk($sformatf("v%0d valid", idx), 32'(DataValidOut), 32'(!v.e_err));
            chk($sformatf("v%0d err", idx), 32'(ErrOut), 32'(v.e_err));
            chk($sformatf("v%0d stall_done", idx), 32'(StallOut), 32'd0);
            chk($sformatf("v%0d data_out", idx), DataOut, v.e_dout);
            chk($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(v.e_stall));
            chk($sformatf("v%0d req_cycles", idx), 32'(req_n), 32'(v.e_req));
            break;
         end
         @(negedge Clk);
      end
      if (!done) begin
         chk($sformatf("v%0d completion_timeout", idx), 32'd0, 32'd1);
         ValidIn = 1'b0; ReadIn = 1'b0; WriteIn = 1'b0; MemAck = 1'b0;
      end
      // Completion pulses last exactly one cycle.
      @(negedge Clk); #1;
      chk($sformatf("v%0d pulse_end", idx), 32'({DataValidOut, ErrOut, MemReq, StallOut}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int req_n;
      // op           rd wr f3    addr        sdata        rdata        ack  e_addr   e_be     e_wdata      we stl req err e_dout
      vecs[0]  = mk(1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 3,  30'h40, 4'b1111, 32'h0,        0, 4,  3,  0, 32'hDEADBEEF); // LW
      vecs[1]  = mk(1, 0, 3'd0, 32'h203, 32'h0,        32'h80FF1234, 1,  30'h80, 4'b1111, 32'h0,        0, 2,  1,  0, 32'hFFFFFF80); // LB
      vecs[2]  = mk(1, 0, 3'd4, 32'h203, 32'h0,        32'h80FF1234, 2,  30'h80, 4'b1111, 32'h0,        0, 3,  2,  0, 32'h00000080); // LBU
      vecs[3]  = mk(0, 1, 3'd1, 32'h302, 32'h0000ABCD, 32'h0,        1,  30'hC0, 4'b1100, 32'hABCDABCD, 1, 2,  1,  0, 32'h00000080); // SH
      vecs[4]  = mk(1, 0, 3'd1, 32'h002, 32'h0,        32'h80FF1234, 1,  30'h0,  4'b1111, 32'h0,        0, 2,  1,  0, 32'hFFFF80FF); // LH
      vecs[5]  = mk(1, 0, 3'd5, 32'h000, 32'h0,        32'h80FF1234, 1,  30'h0,  4'b1111, 32'h0,        0, 2,  1,  0, 32'h00001234); // LHU
      vecs[6]  = mk(0, 1, 3'd0, 32'h001, 32'h12345678, 32'h0,        1,  30'h0,  4'b0010, 32'h78787878, 1, 2,  1,  0, 32'h00001234); // SB
      vecs[7]  = mk(0, 1, 3'd2, 32'h004, 32'hCAFEF00D, 32'h0,        1,  30'h1,  4'b1111, 32'hCAFEF00D, 1, 2,  1,  0, 32'h00001234); // SW
      vecs[8]  = mk(1, 0, 3'd2, 32'h101, 32'h0,        32'h0,        0,  30'h0,  4'b0000, 32'h0,        0, 0,  0,  1, 32'h0);        // LW misaligned
      vecs[9]  = mk(1, 0, 3'd3, 32'h100, 32'h0,        32'h0,        0,  30'h0,  4'b0000, 32'h0,        0, 0,  0,  1, 32'h0);        // funct3 011
      vecs[10] = mk(1, 0, 3'd1, 32'h003, 32'h0,        32'h0,        0,  30'h0,  4'b0000, 32'h0,        0, 0,  0,  1, 32'h0);        // LH misaligned
      vecs[11] = mk(0, 1, 3'd2, 32'h102, 32'h0,        32'h0,        0,  30'h0,  4'b0000, 32'h0,        0, 0,  0,  1, 32'h0);        // SW misaligned
      vecs[12] = mk(1, 1, 3'd2, 32'h010, 32'h55555555, 32'h11223344, 1,  30'h4,  4'b1111, 32'h0,        0, 2,  1,  0, 32'h11223344); // read+write -> read
      vecs[13] = mk(1, 0, 3'd2, 32'h200, 32'h0,        32'h0,        0,  30'h80, 4'b1111, 32'h0,        0, 17, 16, 1, 32'h0);        // timeout
      vecs[14] = mk(0, 1, 3'd4, 32'h000, 32'h0,        32'h0,        0,  30'h0,  4'b0000, 32'h0,        0, 0,  0,  1, 32'h0);        // store funct3 100
      vecs[15] = mk(1, 0, 3'd2, 32'h010, 32'h0,        32'h0BADF00D, 16, 30'h4,  4'b1111, 32'h0,        0, 17, 16, 0, 32'h0BADF00D); // ack in last WAIT cycle
      vecs[16] = mk(0, 1, 3'd0, 32'h00B, 32'h000000A5, 32'h0,        1,  30'h2,  4'b1000, 32'hA5A5A5A5, 1, 2,  1,  0, 32'h0BADF00D); // SB lane 3
      vecs[17] = mk(0, 1, 3'd1, 32'h300, 32'hFFFF1234, 32'h0,        2,  30'hC0, 4'b0011, 32'h12341234, 1, 3,  2,  0, 32'h0BADF00D); // SH lane 0

      // Reset with an access already presented: everything must stay quiet.
      Rst = 1'b1; ValidIn = 1'b1; ReadIn = 1'b1; WriteIn = 1'b0; Funct3In = 3'd2;
      AddrIn = 32'h0; StoreDataIn = 32'h0; MemRData = 32'h0; MemAck = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      chk("reset stall", 32'(StallOut), 32'd0);
      chk("reset mem_req", 32'(MemReq), 32'd0);
      chk("reset data_out", DataOut, 32'd0);
      chk("reset pulses", 32'({DataValidOut, ErrOut}), 32'd0);
      chk("reset mem_if", 32'({MemWe, MemBE, MemAddr[25:0]}), 32'd0);
      ValidIn = 1'b0; ReadIn = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;

      foreach (vecs[i]) run_txn(vecs[i], i);

      // Reset during the 2nd WAIT cycle drops request and stall at once.
      @(negedge Clk);
      ValidIn = 1'b1; ReadIn = 1'b1; WriteIn = 1'b0; Funct3In = 3'd2; AddrIn = 32'h100;
      MemAck = 1'b0;
      req_n = 0;
      for (int c = 0; c < 10 && req_n < 2; c++) begin
         @(negedge Clk); #1;
         if (MemReq) req_n++;
      end
      chk("rst_mid reached_wait2", 32'(req_n), 32'd2);
      Rst = 1'b1;
      #1;
      chk("rst_mid mem_req", 32'(MemReq), 32'd0);
      chk("rst_mid stall", 32'(StallOut), 32'd0);
      chk("rst_mid data_out", DataOut, 32'd0);
      ValidIn = 1'b0; ReadIn = 1'b0;
      @(negedge Clk); #1;
      chk("rst_mid no_pulse", 32'({DataValidOut, ErrOut}), 32'd0);
      Rst = 1'b0;
      run_txn(mk(1, 0, 3'd2, 32'h100, 32'h0, 32'h13579BDF, 2,
                 30'h40, 4'b1111, 32'h0, 0, 3, 2, 0, 32'h13579BDF), 100);

      // Acknowledge while idle is ignored.
      @(negedge Clk);
      MemAck = 1'b1; MemRData = 32'hFFFFFFFF;
      repeat (2) @(negedge Clk);
      #1;
      chk("stray_ack mem_req", 32'(MemReq), 32'd0);
      chk("stray_ack pulses", 32'({DataValidOut, ErrOut}), 32'd0);
      chk("stray_ack data_out", DataOut, 32'h13579BDF);
      MemAck = 1'b0;
      @(negedge Clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
